// File: rtl/motion_est_top.sv
// rtl/motion_est_top.sv - full-search 16x16 block-matching motion estimator
// Sixteen PEs (one per vx) sweep the 32x32 search area; best SAD and vector are reported.
module motion_est_top (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] R,
  input  logic [7:0] S1,
  input  logic [7:0] S2,
  output logic [7:0] AddressR,
  output logic [9:0] AddressS1,
  output logic [9:0] AddressS2,
  output logic [7:0] BestDist,
  output logic [3:0] motionX,
  output logic [3:0] motionY,
  output logic       completed
);

  localparam logic [12:0] LAST = 13'd4112;

  logic [12:0] count, count_d, count_m16;
  logic        run_d;
  logic [7:0]  rdly [1:15];
  logic [15:0] best;
  logic [3:0]  best_x, best_y;
  logic [4:0]  row1, row2;

  logic [15:0] fin;
  logic [15:0] sad [16];
  logic [3:0]  fvy [16];
  logic        hit;
  logic [15:0] hsad;
  logic [3:0]  hx, hy;

  // S2 feeds pixels whose row began one block earlier; deriving it from count-16
  // keeps the row correct when the PE's candidate straddles a vy boundary.
  assign count_m16 = count - 13'd16;
  assign row1      = {1'b0, count[11:8]} + {1'b0, count[7:4]};
  assign row2      = {1'b0, count_m16[11:8]} + {1'b0, count_m16[7:4]};
  assign AddressR  = count[7:0];
  assign AddressS1 = {row1, 1'b0, count[3:0]};
  assign AddressS2 = {row2, 1'b1, count[3:0]};

  genvar k;
  generate
    for (k = 0; k < 16; k++) begin : g_pe
      logic [7:0]  rv, sv, ad;
      logic [12:0] idx;
      logic        ok;
      logic [15:0] acc;

      if (k == 0) begin : g_r0
        assign rv = R;
      end else begin : g_rk
        assign rv = rdly[k];
      end

      assign sv  = (count_d[3:0] >= 4'(k)) ? S1 : S2;
      assign ad  = (rv > sv) ? (rv - sv) : (sv - rv);
      assign idx = count_d - 13'(k);
      assign ok  = run_d && (count_d >= 13'(k)) && !idx[12];

      assign fin[k] = ok && (idx[7:0] == 8'hFF);
      assign sad[k] = acc + {8'd0, ad};
      assign fvy[k] = idx[11:8];

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
          acc <= '0;
        else if (ok)
          acc <= ((idx[7:0] == 8'd0) ? 16'd0 : acc) + {8'd0, ad};
      end
    end
  endgenerate

  // PE finish times never coincide, so at most one fin bit is set per cycle.
  always_comb begin
    hit  = 1'b0;
    hsad = '0;
    hx   = '0;
    hy   = '0;
    for (int i = 0; i < 16; i++) begin
      if (fin[i]) begin
        hit  = 1'b1;
        hsad = sad[i];
        hx   = 4'(i);
        hy   = fvy[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      count_d   <= '0;
      run_d     <= 1'b0;
      for (int i = 1; i < 16; i++) rdly[i] <= '0;
      best      <= 16'hFFFF;
      best_x    <= 4'h8;
      best_y    <= 4'h8;
      completed <= 1'b0;
    end else begin
      count_d <= count;
      run_d   <= start;
      rdly[1] <= R;
      for (int i = 2; i < 16; i++) rdly[i] <= rdly[i-1];

      if (!start)
        count <= '0;
      else if (count != LAST)
        count <= count + 13'd1;

      if (start && count == 13'd0) begin
        best      <= 16'hFFFF;
        best_x    <= 4'h8;
        best_y    <= 4'h8;
        completed <= 1'b0;
      end else begin
        if (hit && hsad < best) begin
          best   <= hsad;
          best_x <= hx;
          best_y <= hy;
        end
        if (start && count == LAST - 13'd1)
          completed <= 1'b1;
      end
    end
  end

  assign BestDist = (best > 16'd255) ? 8'hFF : best[7:0];
  assign motionX  = {~best_x[3], best_x[2:0]};
  assign motionY  = {~best_y[3], best_y[2:0]};

endmodule

// File: tb/tb_motion_est_top.sv
// tb/tb_motion_est_top.sv - directed bench for motion_est_top with behavioural ROMs
module tb_motion_est_top;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] R, S1, S2;
  logic [7:0] AddressR;
  logic [9:0] AddressS1, AddressS2;
  logic [7:0] BestDist;
  logic [3:0] motionX, motionY;
  logic       completed;

  logic [7:0] rom_r [256];
  logic [7:0] rom_s [1024];

  int total = 0;
  int bad   = 0;

  motion_est_top dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .R(R), .S1(S1), .S2(S2),
    .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
    .BestDist(BestDist), .motionX(motionX), .motionY(motionY),
    .completed(completed)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    R  <= rom_r[AddressR];
    S1 <= rom_s[AddressS1];
    S2 <= rom_s[AddressS2];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_s_random();
    for (int i = 0; i < 1024; i++) rom_s[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_match(input int vx, input int vy);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        rom_r[r*16+c] = rom_s[(r+vy)*32 + c + vx];
  endtask

  task automatic run(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                     input logic [7:0] ed);
    int n;
    @(negedge clock) start = 1'b0;
    @(negedge clock) start = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!completed && n < 5000);
    check({tag, "_by4112"}, 32'(n <= 4112), 32'd1);
    check({tag, "_done"}, 32'(completed), 32'd1);
    check({tag, "_dist"}, 32'(BestDist), 32'(ed));
    check({tag, "_mx"}, 32'(motionX), 32'(ex));
    check({tag, "_my"}, 32'(motionY), 32'(ey));
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    fill_s_random();
    fill_match(11, 3);
    repeat (3) @(negedge clock);
    check("rst_dist", 32'(BestDist), 32'hFF);
    check("rst_mx", 32'(motionX), 32'h0);
    check("rst_my", 32'(motionY), 32'h0);
    check("rst_done", 32'(completed), 32'h0);
    reset_n = 1'b1;

    run("m3n5", 4'h3, 4'hB, 8'h00);

    fill_match(0, 0);
    run("corner_lo", 4'h8, 4'h8, 8'h00);

    fill_match(15, 15);
    run("corner_hi", 4'h7, 4'h7, 8'h00);

    fill_match(10, 9);
    rom_r[37] = (rom_r[37] < 8'd128) ? rom_r[37] + 8'd5 : rom_r[37] - 8'd5;
    run("near", 4'h2, 4'h1, 8'h05);

    @(negedge clock) start = 1'b0;
    repeat (10) @(negedge clock);
    check("hold_dist", 32'(BestDist), 32'h05);
    check("hold_mx", 32'(motionX), 32'h2);
    check("hold_my", 32'(motionY), 32'h1);
    check("hold_done", 32'(completed), 32'h1);

    fill_match(4, 12);
    run("restart", 4'hC, 4'h4, 8'h00);

    fill_s_random();
    fill_match(6, 2);
    @(negedge clock) start = 1'b0;
    @(negedge clock) start = 1'b1;
    repeat (2000) @(negedge clock);
    check("pre_rst_dist", 32'(BestDist), 32'h00);
    reset_n = 1'b0;
    #1;
    check("mid_rst_dist", 32'(BestDist), 32'hFF);
    check("mid_rst_mx", 32'(motionX), 32'h0);
    check("mid_rst_my", 32'(motionY), 32'h0);
    check("mid_rst_done", 32'(completed), 32'h0);
    @(negedge clock) start = 1'b0;
    reset_n = 1'b1;
    run("after_rst", 4'hE, 4'hA, 8'h00);

    for (int i = 0; i < 1024; i++) rom_s[i] = 8'h00;
    for (int i = 0; i < 256; i++) rom_r[i] = 8'h80;
    run("nomatch", 4'h8, 4'h8, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motion_est_top.md
Name: motion_est_top

Overview:
- Full-search block-matching motion estimator.
- Finds the displacement (mx, my), each in -8..+7, that minimises the sum of absolute differences (SAD) between a 16x16 reference block R and a 16x16 window taken from a 32x32 search area S.
- Sits between two external synchronous ROMs: a 256-byte reference ROM and a 1024-byte dual-read-port search ROM.
- Reports the best SAD (saturated to 8 bits) and the motion vector as 4-bit two's-complement values.

Parameters:
- None. Block 16x16, search area 32x32, 8-bit pixels, 16 PEs are fixed.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level; high = run/continue search, low = idle (results held)
- R  in  8  reference pixel, valid 1 cycle after AddressR
- S1  in  8  search pixel, valid 1 cycle after AddressS1
- S2  in  8  search pixel, valid 1 cycle after AddressS2
- AddressR  out  8  reference ROM address (row*16+col)
- AddressS1  out  10  search ROM port-1 address (row*32+col)
- AddressS2  out  10  search ROM port-2 address
- BestDist  out  8  minimum SAD, saturated at 8'hFF
- motionX  out  4  best mx, two's complement
- motionY  out  4  best my, two's complement
- completed  out  1  high when search finished; held until next search

Behaviour:
- Reset (async, reset_n=0): count=0, BestDist=8'hFF, motionX=0, motionY=0, completed=0, all PE accumulators=0.
- Counter count[12:0]:
  - start=0: count cleared to 0; outputs hold.
  - start=1 and count<4112: count increments every clock.
  - At 4112: count holds.
  - The first clock with start=1 and count=0 reloads the internal best to 16'hFFFF and clears completed.
- Address generation, combinational from count (vy=count[11:8], r=count[7:4], c=count[3:0]):
  - AddressR = count[7:0].
  - AddressS1 = (r+vy)*32 + c.
  - AddressS2 = (AddressS1 - 16) mod 1024.
- ROMs: synchronous read with 1-cycle latency, so data for count t arrives at t+1.
- Candidate mapping: vx=mx+8, vy=my+8. Candidate (vx,vy) compares R[r][c] with S[(r+vy)*32 + c+vx].
- Processing elements: 16 PEs, PE k computes vx=k.
  - R is shifted through the PE chain, so PE k sees R delayed k cycles.
  - S1 and S2 are broadcast to all PEs.
  - PE k uses S1 when the current address column c >= k, else S2.
  - |R-S| is computed as 8-bit unsigned and accumulated in 16 bits, with no overflow possible (max 65280).
  - The accumulator restarts at PE-local pixel index 0.
- Candidate completion: PE k finishes candidate (k,vy) when its pixel index 255 is accumulated, i.e. count ≈ 256*vy + 255 + k + pipeline latency.
  - vy is pipelined alongside the data so each result carries its own vy.
- Comparator:
  - A finished SAD strictly less than the internal best replaces best, bestX=k, bestY=vy.
  - Ties keep the earlier candidate.
- Outputs:
  - BestDist = best>255 ? 8'hFF : best[7:0].
  - motionX = {~bestX[3], bestX[2:0]}, i.e. vx-8.
  - motionY = {~bestY[3], bestY[2:0]}, i.e. vy-8.
  - These update on the clock after the comparison.
- Completion:
  - All 256 candidates are evaluated by count 4112.
  - completed=1 no later than the clock edge at which count reaches 4112.
  - completed stays high, with outputs stable, while start remains high or goes low, until a new search begins or reset.
- Boundaries:
  - An S2 address that wraps (r+vy=0, c<16) is don't-care and is never selected for a valid candidate.
  - A start drop mid-search aborts: count returns to 0, completed stays 0, partial best is discarded at the next start.
  - reset_n asserted mid-search returns all outputs to reset values immediately.

Test Plan:
- Exact match, mx=+3, my=-5: R copied from S offset 256+8+(r-5)*32+(c+3); hold start 4112 cycles -> BestDist=0, motionX=4'h3, motionY=4'hB, completed=1.
- Corner candidates: exact match at (-8,-8), then in a separate run at (+7,+7) -> motionX/motionY = 8/8, then 7/7; BestDist=0.
- Near match: exact match at (2,1) plus one R pixel altered by 5 -> BestDist=5, motionX=2, motionY=1.
- No match: S all 8'h00, R all 8'h80 -> BestDist=8'hFF (saturated), motionX=8, motionY=8 (first candidate kept on ties).
- Hold/restart: after completion drop start 10 cycles -> outputs unchanged; rerun with new R -> new result.
- Reset mid-search: assert reset_n=0 at count=2000 -> BestDist=8'hFF, motionX=0, motionY=0, completed=0 immediately; full rerun then gives the correct vector.
